// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
// Sequencing controller for a loadable up-counter. Converts a
// start/stop/pause command interface into the counter's clear/load/enable
// controls. Runs the counter from a latched preset to a latched limit in
// one-shot or periodic mode and reports each terminal count with a
// registered one-cycle done pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   start      run request, accepted only in IDLE (latches preset/limit/mode)
//   stop       abort request, honoured in LOAD/RUN/HOLD
//   pause      freezes counting while high in RUN/HOLD
//   mode       0 = one-shot, 1 = periodic
//   preset     start value
//   limit      terminal value
//   cnt_out    counter value feedback
//   cnt_load   counter load strobe
//   cnt_enab   counter increment enable
//   cnt_clr    counter synchronous clear
//   cnt_in     counter load value (latched preset)
//   busy       high whenever the controller is not IDLE
//   done       one-cycle pulse, cycle after the terminal match
//   period_cnt done pulses since the last accepted start (saturating)
//
// State | meaning
// IDLE  | waiting for start, counter controls all low
// LOAD  | one cycle of cnt_load, counter takes the preset
// RUN   | counting toward limit; terminal match, stop, pause evaluated
// HOLD  | counting frozen by pause, terminal match not evaluated
// CLEAR | one cycle of cnt_clr after a stop, then IDLE

module counter_seq_ctrl #(
  parameter int WIDTH  = 9,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              mode,
  input  logic [WIDTH-1:0]  preset,
  input  logic [WIDTH-1:0]  limit,
  input  logic [WIDTH-1:0]  cnt_out,
  output logic              cnt_load,
  output logic              cnt_enab,
  output logic              cnt_clr,
  output logic [WIDTH-1:0]  cnt_in,
  output logic              busy,
  output logic              done,
  output logic [PCNT_W-1:0] period_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_HOLD  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  localparam logic [PCNT_W-1:0] PCNT_MAX = '1;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  preset_q, preset_d;
  logic [WIDTH-1:0]  limit_q, limit_d;
  logic              mode_q, mode_d;
  logic              done_q, done_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              match;

  assign match = (cnt_out == limit_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      preset_q <= '0;
      limit_q  <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      pcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      limit_q  <= limit_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      pcnt_q   <= pcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    limit_d  = limit_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    pcnt_d   = pcnt_q;
    cnt_load = 1'b0;
    cnt_enab = 1'b0;
    cnt_clr  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // start wins over a simultaneous stop: stop means nothing here
        if (start) begin
          preset_d = preset;
          limit_d  = limit;
          mode_d   = mode;
          pcnt_d   = '0;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        cnt_load = 1'b1;
        state_d  = stop ? S_CLEAR : S_RUN;
      end

      S_RUN: begin
        if (stop) begin
          state_d = S_CLEAR;
        end else if (match) begin
          done_d  = 1'b1;
          state_d = mode_q ? S_LOAD : S_IDLE;
          if (pcnt_q != PCNT_MAX) begin
            pcnt_d = pcnt_q + PCNT_W'(1);
          end
        end else if (pause) begin
          state_d = S_HOLD;
        end else begin
          cnt_enab = 1'b1;
        end
      end

      S_HOLD: begin
        if (stop) begin
          state_d = S_CLEAR;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end

      S_CLEAR: begin
        cnt_clr = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cnt_in     = preset_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign period_cnt = pcnt_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       mode = 1'b0;
  logic [8:0] preset = '0;
  logic [8:0] limit = '0;
  logic [8:0] cnt_out;
  logic       cnt_load, cnt_enab, cnt_clr;
  logic [8:0] cnt_in;
  logic       busy, done;
  logic [7:0] period_cnt;

  int checks = 0;
  int failures = 0;

  counter_seq_ctrl #(.WIDTH(9), .PCNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .preset(preset), .limit(limit), .cnt_out(cnt_out),
    .cnt_load(cnt_load), .cnt_enab(cnt_enab), .cnt_clr(cnt_clr),
    .cnt_in(cnt_in), .busy(busy), .done(done), .period_cnt(period_cnt)
  );

  always #5 clk = ~clk;

  // behavioural counter: clear > load > enable, wraps mod 512
  logic [8:0] model_cnt = '0;
  always_ff @(posedge clk) begin
    if (cnt_clr)       model_cnt <= '0;
    else if (cnt_load) model_cnt <= cnt_in;
    else if (cnt_enab) model_cnt <= model_cnt + 9'd1;
  end
  assign cnt_out = model_cnt;

  typedef struct {
    logic [8:0] preset;
    logic [8:0] limit;
    int         exp_edge;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // leaves the bench just after E0
  task automatic start_run(input logic [8:0] p, input logic [8:0] l, input logic m);
    preset = p;
    limit  = l;
    mode   = m;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int e_start, input int budget, output int e_done);
    int e;
    e = e_start;
    while (done !== 1'b1 && e < e_start + budget) begin
      tick();
      e++;
    end
    e_done = (done === 1'b1) ? e : -1;
  endtask

  task automatic idle_gap();
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  e;
    bit  saw_done;

    vecs[0] = '{preset: 9'h003, limit: 9'h007, exp_edge: 6};
    vecs[1] = '{preset: 9'h000, limit: 9'h00A, exp_edge: 12};
    vecs[2] = '{preset: 9'h0AA, limit: 9'h0AA, exp_edge: 2};
    vecs[3] = '{preset: 9'h1FE, limit: 9'h001, exp_edge: 5};
    vecs[4] = '{preset: 9'h100, limit: 9'h0FF, exp_edge: 513};

    // reset state
    #22;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_load", cnt_load, 0);
    chk("rst_enab", cnt_enab, 0);
    chk("rst_clr", cnt_clr, 0);
    chk("rst_cnt_in", cnt_in, 0);
    chk("rst_pcnt", period_cnt, 0);
    #1 rst = 1'b1;
    tick();

    // one-shot 3 -> 7, cycle by cycle
    start_run(9'h003, 9'h007, 1'b0);
    chk("t1_busy_e0", busy, 1);
    chk("t1_load_e0", cnt_load, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("t1_cnt_e%0d", k), cnt_out, 32'(2 + k));
      chk($sformatf("t1_done_e%0d", k), done, 0);
    end
    chk("t1_enab_match", cnt_enab, 0);
    tick();
    chk("t1_done_e6", done, 1);
    chk("t1_busy_e6", busy, 0);
    chk("t1_pcnt", period_cnt, 1);
    tick();
    chk("t1_done_e7", done, 0);
    idle_gap();

    // table of one-shot runs, including preset==limit and wrap-through-0
    for (int i = 0; i < 5; i++) begin
      start_run(vecs[i].preset, vecs[i].limit, 1'b0);
      wait_done(0, 600, e);
      chk($sformatf("vec%0d_edge", i), e, vecs[i].exp_edge);
      chk($sformatf("vec%0d_cnt", i), cnt_out, vecs[i].limit);
      chk($sformatf("vec%0d_busy", i), busy, 0);
      chk($sformatf("vec%0d_pcnt", i), period_cnt, 1);
      tick();
      chk($sformatf("vec%0d_done_off", i), done, 0);
      idle_gap();
    end

    // periodic 0x1FC -> 0x002: D=6, period 8
    start_run(9'h1FC, 9'h002, 1'b1);
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk($sformatf("t2_done_e%0d", k), done, (k % 8 == 0) ? 1 : 0);
      if (k % 8 == 0) chk($sformatf("t2_pcnt_e%0d", k), period_cnt, 32'(k / 8));
      if (k == 4) chk("t2_cnt_1ff", cnt_out, 9'h1FF);
      if (k == 5) chk("t2_cnt_wrap", cnt_out, 9'h000);
      chk($sformatf("t2_busy_e%0d", k), busy, 1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("t2_stopped", busy, 0);
    idle_gap();

    // pause seen on two edges: three frozen cycles, done 3 edges late (12 -> 15)
    start_run(9'h000, 9'h00A, 1'b0);
    repeat (3) tick();
    chk("t3_cnt_e3", cnt_out, 2);
    pause = 1'b1;
    tick();
    chk("t3_cnt_e4", cnt_out, 2);
    tick();
    chk("t3_cnt_e5", cnt_out, 2);
    chk("t3_enab_hold", cnt_enab, 0);
    pause = 1'b0;
    tick();
    chk("t3_cnt_e6", cnt_out, 2);
    wait_done(6, 40, e);
    chk("t3_edge", e, 15);
    idle_gap();

    // stop in RUN at cnt_out=5
    start_run(9'h000, 9'h00A, 1'b0);
    repeat (6) tick();
    chk("t4_cnt5", cnt_out, 5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_clr", cnt_clr, 1);
    chk("t4_busy_clr", busy, 1);
    tick();
    chk("t4_cnt0", cnt_out, 0);
    chk("t4_idle", busy, 0);
    chk("t4_clr_off", cnt_clr, 0);
    saw_done = 0;
    repeat (12) begin
      if (done) saw_done = 1;
      tick();
    end
    chk("t4_no_done", saw_done, 0);
    chk("t4_pcnt", period_cnt, 0);

    // stop in HOLD
    start_run(9'h000, 9'h00A, 1'b0);
    repeat (4) tick();
    pause = 1'b1;
    repeat (2) tick();
    stop = 1'b1;
    tick();
    stop  = 1'b0;
    pause = 1'b0;
    chk("t4h_clr", cnt_clr, 1);
    chk("t4h_done", done, 0);
    tick();
    chk("t4h_idle", busy, 0);
    chk("t4h_cnt0", cnt_out, 0);
    idle_gap();

    // stop on the terminal-match cycle: CLEAR wins, no done
    start_run(9'h003, 9'h007, 1'b0);
    repeat (5) tick();
    chk("t5s_cnt7", cnt_out, 7);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t5s_done_e6", done, 0);
    chk("t5s_clr", cnt_clr, 1);
    tick();
    chk("t5s_done_e7", done, 0);
    chk("t5s_idle", busy, 0);
    chk("t5s_pcnt", period_cnt, 0);
    idle_gap();

    // start while busy with new preset/limit/mode: ignored
    start_run(9'h003, 9'h007, 1'b0);
    repeat (2) tick();
    preset = 9'h050;
    limit  = 9'h060;
    mode   = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("t5b_cnt_in", cnt_in, 3);
    wait_done(3, 20, e);
    chk("t5b_edge", e, 6);
    chk("t5b_busy", busy, 0);
    idle_gap();
    chk("t5b_stay_idle", busy, 0);

    // start and stop together in IDLE: start accepted
    preset = 9'h003;
    limit  = 9'h007;
    mode   = 1'b0;
    start  = 1'b1;
    stop   = 1'b1;
    tick();
    start  = 1'b0;
    stop   = 1'b0;
    chk("t5c_busy", busy, 1);
    chk("t5c_load", cnt_load, 1);
    wait_done(0, 20, e);
    chk("t5c_edge", e, 6);
    idle_gap();

    // period_cnt saturation: periodic with preset==limit, done every 2 cycles
    start_run(9'h005, 9'h005, 1'b1);
    repeat (520) tick();
    chk("t5d_pcnt_sat", period_cnt, 255);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("t5d_idle", busy, 0);
    idle_gap();

    // asynchronous reset mid-RUN, between edges
    start_run(9'h1FC, 9'h002, 1'b1);
    repeat (11) tick();
    chk("t6_pre_enab", cnt_enab, 1);
    chk("t6_pre_pcnt", period_cnt, 1);
    #3 rst = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_enab", cnt_enab, 0);
    chk("t6_load", cnt_load, 0);
    chk("t6_clr", cnt_clr, 0);
    chk("t6_cnt_in", cnt_in, 0);
    chk("t6_pcnt", period_cnt, 0);
    chk("t6_done", done, 0);
    #2 rst = 1'b1;
    tick();
    start_run(9'h003, 9'h007, 1'b0);
    wait_done(0, 20, e);
    chk("t6_restart_edge", e, 6);
    chk("t6_restart_pcnt", period_cnt, 1);
    chk("t6_restart_cnt", cnt_out, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
